jtvigil_rom_arb: RTL

JTVIGIL_ROM_ARB -- requirements
Module: jtvigil_rom_arb

---
 rtl/jtvigil_rom_arb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/jtvigil_rom_arb.sv
// Per-slot one-entry ROM caches sharing a single SDRAM read port.
// Define JTVIGIL_ROM_RROBIN_EN for round-robin grant; otherwise lowest missing slot wins.
module jtvigil_rom_arb #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_data,
  output logic [21:0]         ba_addr,
  output logic                ba_rd,
  input  logic                ba_ack,
  input  logic                ba_dok,
  input  logic                ba_rdy,
  input  logic [15:0]         data_read
);

  localparam int CW = (DW == 32) ? 32 : 16;
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t          state;
  logic [SLOTS-1:0] valid;
  logic [21:0]     tag   [SLOTS];
  logic [CW-1:0]   cache [SLOTS];
  logic [21:0]     waddr [SLOTS];
  logic [SLOTS-1:0] miss;
  logic [IW-1:0]   gnt, gnt_next;
  logic            any_miss;
  logic [1:0]      wcnt;
  logic            flushed;
  logic [CW-1:0]   fill_data, fill_next;
`ifdef JTVIGIL_ROM_RROBIN_EN
  logic [IW-1:0]   ptr;
`endif

  function automatic logic [21:0] word_addr(input logic [AW-1:0] a);
    logic [63:0] w;
    w = 64'(a);
    if (DW == 8)       w = w >> 1;
    else if (DW == 32) w = w << 1;
    return w[21:0];
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      waddr[i]   = word_addr(slot_addr[i*AW +: AW]);
      slot_ok[i] = slot_cs[i] & valid[i] & (tag[i] == waddr[i]);
      miss[i]    = slot_cs[i] & ~slot_ok[i];
      slot_data[i*DW +: DW] = DW'((DW == 8 && slot_addr[i*AW]) ? (cache[i] >> 8) : cache[i]);
    end
  end

  always_comb begin
    int unsigned k;
    k        = 0;
    any_miss = 1'b0;
    gnt_next = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
`ifdef JTVIGIL_ROM_RROBIN_EN
      k = 32'(ptr) + i;
      if (k >= SLOTS) k = k - SLOTS;
`else
      k = i;
`endif
      if (!any_miss && miss[k]) begin
        any_miss = 1'b1;
        gnt_next = IW'(k);
      end
    end
  end

  // Merge the word arriving this cycle so ba_rdy coincident with ba_dok stores it.
  always_comb begin
    fill_next = fill_data;
    if (ba_dok) begin
      if (wcnt == 2'd0)                    fill_next[15:0]       = data_read;
      else if (CW == 32 && wcnt == 2'd1)   fill_next[CW-1:CW-16] = data_read;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ba_rd     <= 1'b0;
      ba_addr   <= '0;
      gnt       <= '0;
      wcnt      <= '0;
      flushed   <= 1'b0;
      fill_data <= '0;
      valid     <= '0;
`ifdef JTVIGIL_ROM_RROBIN_EN
      ptr       <= '0;
`endif
      for (int unsigned i = 0; i < SLOTS; i++) begin
        tag[i]   <= '0;
        cache[i] <= '0;
      end
    end else begin
      if (flush) valid <= '0;
      case (state)
        IDLE: if (any_miss) begin
          gnt       <= gnt_next;
          ba_addr   <= waddr[gnt_next];
          ba_rd     <= 1'b1;
          wcnt      <= '0;
          fill_data <= '0;
          flushed   <= 1'b0;
`ifdef JTVIGIL_ROM_RROBIN_EN
          ptr       <= (32'(gnt_next) == SLOTS - 1) ? '0 : gnt_next + 1'b1;
`endif
          state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (flush) flushed <= 1'b1;
          if (ba_ack) begin
            ba_rd <= 1'b0;
            state <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (flush) flushed <= 1'b1;
          if (ba_dok && wcnt != 2'd2) begin
            fill_data <= fill_next;
            wcnt      <= wcnt + 2'd1;
          end
          if (ba_rdy) begin
            cache[gnt] <= fill_next;
            tag[gnt]   <= ba_addr;
            valid[gnt] <= !(flush || flushed);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
